neuron_mac_seq: RTL and testbench

//  Downstream consumer of one neuron's weight BRAM: sequences read addresses into the weight

---
 rtl/ann_pkg.sv | 33 +++
 rtl/q88_saturate.sv | 25 ++
 rtl/neuron_mac_seq.sv | 99 +++++++++
 tb/tb_neuron_mac_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared Q8.8 definitions for the ANN datapath: widths, saturation limits,
// FSM state type and the Q8.8 clamp helper.
package ann_pkg;

  localparam int DW         = 16;
  localparam int FRAC       = 8;
  localparam int N_TAPS_DEF = 28;
  localparam int AW_DEF     = 5;

  localparam logic [DW-1:0] Q88_MAX = 16'h7FFF;
  localparam logic [DW-1:0] Q88_MIN = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SAT,
    S_HOLD
  } state_t;

  // Clamp an already-shifted signed value into the Q8.8 range.
  function automatic logic [DW-1:0] sat_q88(input logic signed [63:0] v);
    logic [DW-1:0] r;
    if (v > 64'sd32767)
      r = Q88_MAX;
    else if (v < -64'sd32768)
      r = Q88_MIN;
    else
      r = v[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/q88_saturate.sv
// Combinational accumulator-to-Q8.8 conversion: drop FRAC bits, clamp to 16 bits.
// With NEURON_RELU_EN defined, negative results are additionally forced to zero.
module q88_saturate
  import ann_pkg::*;
#(
  parameter int ACC_W = 37
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [DW-1:0]           result
);

  logic signed [ACC_W-1:0] shifted;
  logic [DW-1:0]           clamped;

  always_comb begin
    shifted = acc >>> FRAC;
    clamped = sat_q88(64'(shifted));
`ifdef NEURON_RELU_EN
    result  = clamped[DW-1] ? '0 : clamped;
`else
    result  = clamped;
`endif
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// One hidden-layer neuron: streams N_TAPS weight/pixel pairs, accumulates with bias,
// returns a saturated Q8.8 result under valid/ready. Optional ReLU via NEURON_RELU_EN.
module neuron_mac_seq
  import ann_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] BIAS,
  output logic [AW-1:0] ADDR,
  output logic          EN,
  input  logic [DW-1:0] W_DO,
  input  logic [DW-1:0] X_DO,
  output logic          BUSY,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY
);

  localparam int            ACC_W = 2*DW + AW;
  localparam logic [AW-1:0] LAST  = AW'(N_TAPS - 1);

  state_t                  state, state_next;
  logic signed [2*DW-1:0]  prod;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic [DW-1:0]           sat_result;
  logic                    last_addr;

  assign last_addr = (ADDR == LAST);
  assign bias_ext  = {{(ACC_W-DW-FRAC){BIAS[DW-1]}}, BIAS, {FRAC{1'b0}}};
  assign prod_ext  = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge CLK) begin
    if (!RST_N)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (START) state_next = S_RUN;
      S_RUN:   if (last_addr) state_next = S_DRAIN;
      S_DRAIN: state_next = S_SAT;
      S_SAT:   state_next = S_HOLD;
      S_HOLD:  if (OUT_READY) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    EN        = (state == S_RUN);
    BUSY      = (state != S_IDLE);
    OUT_VALID = (state == S_HOLD);
  end

  // Memory data for the address issued last cycle is present whenever EN is high;
  // prod_valid then lags one more cycle to gate the accumulate.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ADDR       <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      OUT_DATA   <= '0;
    end else begin
      prod_valid <= EN;
      if (EN)
        prod <= $signed(W_DO) * $signed(X_DO);
      if (prod_valid)
        acc <= acc + prod_ext;
      case (state)
        S_IDLE: begin
          if (START) begin
            ADDR <= '0;
            acc  <= bias_ext;
          end
        end
        S_RUN:  if (!last_addr) ADDR <= ADDR + AW'(1);
        S_SAT:  OUT_DATA <= sat_result;
        S_HOLD: if (OUT_READY) ADDR <= '0;
        default: ;
      endcase
    end
  end

  q88_saturate #(.ACC_W(ACC_W)) u_sat (
    .acc    (acc),
    .result (sat_result)
  );

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed and randomized self-checking bench for neuron_mac_seq with
// negedge-read weight BRAM and pixel buffer models.
module tb_neuron_mac_seq;

  localparam int N = 28;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] BIAS;
  logic [4:0]  ADDR;
  logic        EN;
  logic [15:0] W_DO;
  logic [15:0] X_DO;
  logic        BUSY;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  logic [15:0] wmem [N];
  logic [15:0] xmem [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  neuron_mac_seq dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BIAS      (BIAS),
    .ADDR      (ADDR),
    .EN        (EN),
    .W_DO      (W_DO),
    .X_DO      (X_DO),
    .BUSY      (BUSY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY)
  );

  always @(negedge CLK) begin
    if (EN) begin
      W_DO <= wmem[ADDR];
      X_DO <= xmem[ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < N; i++) begin
      wmem[i] = w;
      xmem[i] = x;
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] b);
    longint acc;
    logic [15:0] r;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < N; i++)
      acc += longint'($signed(wmem[i])) * longint'($signed(xmem[i]));
    acc = acc >>> 8;
    if (acc > 32767)
      r = 16'h7FFF;
    else if (acc < -32768)
      r = 16'h8000;
    else
      r = acc[15:0];
`ifdef NEURON_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  // mode 0: ready held high; 1: random ready; 2: ready low 10 cycles with START pulses.
  task automatic run_pass(input string tag, input logic [15:0] bias_in,
                          input logic [15:0] expd, input int mode);
    int cyc;
    int idx;
    bit ready_now;
    bit done;
    @(negedge CLK);
    BIAS      = bias_in;
    START     = 1'b1;
    OUT_READY = (mode == 0);
    @(posedge CLK); #1;
    START = 1'b0;
    BIAS  = 16'($urandom);
    check({tag, " busy_on_start"}, BUSY, 1);
    cyc = 0;
    idx = 0;
    while (!OUT_VALID && cyc < 100) begin
      if (EN) begin
        check({tag, " addr_seq"}, ADDR, idx);
        idx++;
      end
      if (mode == 1) OUT_READY = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, " valid_latency"}, cyc, N + 2);
    check({tag, " addr_count"}, idx, N);
    check({tag, " out_data"}, OUT_DATA, expd);
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (mode == 1) OUT_READY = (n >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 2) begin
        OUT_READY = (n >= 10);
        START     = (n < 10) && n[0];
      end
      ready_now = OUT_READY;
      @(posedge CLK); #1;
      if (ready_now) begin
        check({tag, " valid_drop"}, OUT_VALID, 0);
        check({tag, " busy_drop"}, BUSY, 0);
        done = 1'b1;
      end else begin
        check({tag, " valid_held"}, OUT_VALID, 1);
        check({tag, " data_held"}, OUT_DATA, expd);
        check({tag, " busy_held"}, BUSY, 1);
      end
    end
    START = 1'b0;
    check({tag, " handshake_done"}, done, 1);
    @(posedge CLK); #1;
    check({tag, " idle_no_queue"}, EN, 0);
  endtask

  initial begin
    logic [15:0] b;
    RST_N     = 1'b0;
    START     = 1'b0;
    BIAS      = 16'h0000;
    OUT_READY = 1'b0;
    fill(16'h0100, 16'h0100);
    repeat (3) @(posedge CLK);
    #1;
    check("reset EN", EN, 0);
    check("reset BUSY", BUSY, 0);
    check("reset OUT_VALID", OUT_VALID, 0);
    check("reset OUT_DATA", OUT_DATA, 0);
    check("reset ADDR", ADDR, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_pass("ones", 16'h0000, 16'h1C00, 0);
    fill(16'h7FFF, 16'h7FFF);
    run_pass("pos_sat", 16'h7FFF, 16'h7FFF, 0);
    fill(16'h8000, 16'h7FFF);
`ifdef NEURON_RELU_EN
    run_pass("neg_sat", 16'h0000, 16'h0000, 0);
`else
    run_pass("neg_sat", 16'h0000, 16'h8000, 0);
`endif
    fill(16'h0180, 16'hFF00);
`ifdef NEURON_RELU_EN
    run_pass("mixed_hold", 16'h0200, 16'h0000, 2);
`else
    run_pass("mixed_hold", 16'h0200, 16'hD800, 2);
`endif
    fill(16'hFFFF, 16'h0001);
`ifdef NEURON_RELU_EN
    run_pass("floor", 16'h0000, 16'h0000, 0);
`else
    run_pass("floor", 16'h0000, 16'hFFFF, 0);
`endif
    fill(16'h0001, 16'h0001);
    run_pass("tiny", 16'h0000, 16'h0000, 0);

    fill(16'h0080, 16'h0400);
    @(negedge CLK);
    START = 1'b1;
    BIAS  = 16'hFF00;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (11) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check("midreset EN", EN, 0);
    check("midreset BUSY", BUSY, 0);
    check("midreset OUT_VALID", OUT_VALID, 0);
    check("midreset ADDR", ADDR, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_pass("after_rst", 16'hFF00, 16'h3700, 0);

    for (int p = 0; p < 200; p++) begin
      for (int i = 0; i < N; i++) begin
        wmem[i] = 16'($signed(16'($urandom)) >>> $urandom_range(0, 7));
        xmem[i] = 16'($signed(16'($urandom)) >>> $urandom_range(0, 7));
      end
      b = 16'($urandom);
      run_pass("rand", b, model(b), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
